// File: rtl/led_pattern_fader.sv
// led_pattern_fader: decodes the LED-move state code into an 8-LED pattern
// and drives the board LEDs, cross-fading between patterns by PWM.
// Optional feature macro: LED_FADE_EN (defined = PWM cross-fade, undefined =
// patterns switch immediately and busy stays low).
module led_pattern_fader #(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] state_code,
  output logic [7:0] led,
  output logic       busy,
  output logic       code_err
);

  // Codes 11..62 are the only ones the state counter should ever produce.
  function automatic logic code_valid(input logic [7:0] code);
    return (code >= 8'd11) && (code <= 8'd62);
  endfunction

  // Tens digit picks the pattern family, units digit the position within it.
  function automatic logic [7:0] decode_pat(input logic [7:0] code);
    logic [7:0] t;
    logic [3:0] u;
    logic [2:0] p;
    logic [7:0] pat;
    t   = code / 8'd10;
    u   = 4'(code % 8'd10);
    p   = 3'(u % 4'd8);
    pat = 8'h00;
    if (code_valid(code)) begin
      case (t)
        8'd1:    pat = 8'h01 << p;
        8'd2:    pat = (8'h01 << p) | (8'h80 >> p);
        // 8-bit wraparound makes p=7 give 0x00-1 = 0xFF as required.
        8'd3:    pat = (8'h02 << p) - 8'h01;
        8'd4:    pat = 8'hFF << p;
        8'd5:    pat = u[0] ? 8'hAA : 8'h55;
        8'd6:    pat = u[0] ? 8'h00 : 8'hFF;
        default: pat = 8'h00;
      endcase
    end
    return pat;
  endfunction

  logic [7:0] q1_q, q2_q, acc_code_q;
  logic       code_err_q;
  logic       accept;
  logic [7:0] dec_pat;
  logic [7:0] cur_pat_q;

  // A code is taken only after two matching samples, so one-cycle glitches are dropped.
  always_comb begin
    accept  = (q1_q == q2_q) && (q2_q != acc_code_q);
    dec_pat = decode_pat(acc_code_q);
  end

  // Two-stage input capture and acceptance of a new stable code.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1_q       <= 8'h00;
      q2_q       <= 8'h00;
      acc_code_q <= 8'h00;
      code_err_q <= 1'b0;
    end else begin
      q1_q <= state_code;
      q2_q <= q1_q;
      if (accept) begin
        acc_code_q <= q2_q;
        code_err_q <= !code_valid(q2_q);
      end
    end
  end

  assign code_err = code_err_q;

`ifdef LED_FADE_EN

  typedef enum logic {IDLE, FADE} state_t;

  localparam logic [PWM_BITS:0] MAX_W  = {1'b0, {PWM_BITS{1'b1}}};
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS + 1)'(FADE_STEP);

  state_t              state_q, state_d;
  logic [7:0]          cur_pat_d;
  logic [7:0]          tgt_pat_q, tgt_pat_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0]          led_q, led_d;
  logic [PWM_BITS:0]   level_sum;
  logic                pwm_wrap;
  logic [7:0]          mix_pat;

  // Next-state and LED mix: IDLE shows cur_pat, FADE blends cur_pat into tgt_pat.
  always_comb begin
    state_d   = state_q;
    cur_pat_d = cur_pat_q;
    tgt_pat_d = tgt_pat_q;
    level_d   = level_q;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_wrap  = (pwm_cnt_q == {PWM_BITS{1'b1}});
    level_sum = {1'b0, level_q} + STEP_W;
    // Bits common to both patterns stay lit; differing bits share each PWM period.
    mix_pat   = (cur_pat_q & tgt_pat_q)
              | (tgt_pat_q & ~cur_pat_q & {8{pwm_cnt_q <  level_q}})
              | (cur_pat_q & ~tgt_pat_q & {8{pwm_cnt_q >= level_q}});
    led_d     = cur_pat_q;
    case (state_q)
      IDLE: begin
        led_d = cur_pat_q;
        if (dec_pat != cur_pat_q) begin
          tgt_pat_d = dec_pat;
          level_d   = '0;
          state_d   = FADE;
        end
      end
      FADE: begin
        led_d = mix_pat;
        if (pwm_wrap) begin
          if (level_sum > MAX_W) begin
            cur_pat_d = tgt_pat_q;
            state_d   = IDLE;
          end else begin
            level_d = level_sum[PWM_BITS-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, fade bookkeeping and the registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_pat_q <= 8'h00;
      tgt_pat_q <= 8'h00;
      level_q   <= '0;
      pwm_cnt_q <= '0;
      led_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      cur_pat_q <= cur_pat_d;
      tgt_pat_q <= tgt_pat_d;
      level_q   <= level_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q == FADE);

`else

  // The fade parameters have no effect when the cross-fade is compiled out.
  logic unused_params;
  assign unused_params = ^{PWM_BITS[0], FADE_STEP[0]};

  // Without fading the shown pattern simply follows the decode one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pat_q <= 8'h00;
    end else begin
      cur_pat_q <= dec_pat;
    end
  end

  assign led  = cur_pat_q;
  assign busy = 1'b0;

`endif

endmodule

// File: tb/tb_led_pattern_fader.sv
// Bench for led_pattern_fader: table of codes with a scoreboard of expected
// steady outputs, plus hand-written sequences for latency, glitch rejection,
// last-code-wins, fade ramp (LED_FADE_EN builds) and mid-fade reset.
module tb_led_pattern_fader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] state_code;
  logic [7:0] led;
  logic       busy;
  logic       code_err;

  led_pattern_fader #(.PWM_BITS(8), .FADE_STEP(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .state_code(state_code),
    .led       (led),
    .busy      (busy),
    .code_err  (code_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic [7:0] led;
    logic       err;
  } vec_t;

  vec_t vecs[19];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c);
    @(negedge clk);
    state_code = c;
  endtask

  // Waits until busy has been low for several cycles; counts busy rises and
  // cycles where all eight LEDs were lit.
  task automatic settle(output int rises, output int ff_seen);
    int   quiet;
    int   n;
    logic prev_busy;
    quiet = 0; n = 0; rises = 0; ff_seen = 0;
    prev_busy = busy;
    while (quiet < 6 && n < 10000) begin
      @(posedge clk); #1;
      n++;
      if (busy && !prev_busy) rises++;
      if (led == 8'hFF) ff_seen++;
      prev_busy = busy;
      quiet = (busy || n < 4) ? 0 : quiet + 1;
    end
    if (quiet < 6) begin
      n_cmp++;
      n_err++;
      $display("FAIL settle: busy still high after %0d cycles", n);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, f;
    vec_t e;

    vecs[0]  = '{8'd11,  8'h02, 1'b0};
    vecs[1]  = '{8'd23,  8'h18, 1'b0};
    vecs[2]  = '{8'd37,  8'hFF, 1'b0};
    vecs[3]  = '{8'd45,  8'hE0, 1'b0};
    vecs[4]  = '{8'd52,  8'h55, 1'b0};
    vecs[5]  = '{8'd62,  8'hFF, 1'b0};
    vecs[6]  = '{8'd70,  8'h00, 1'b1};
    vecs[7]  = '{8'd0,   8'h00, 1'b1};
    vecs[8]  = '{8'd12,  8'h04, 1'b0};
    vecs[9]  = '{8'd20,  8'h81, 1'b0};
    vecs[10] = '{8'd29,  8'h42, 1'b0};
    vecs[11] = '{8'd39,  8'h03, 1'b0};
    vecs[12] = '{8'd49,  8'hFE, 1'b0};
    vecs[13] = '{8'd51,  8'hAA, 1'b0};
    vecs[14] = '{8'd61,  8'h00, 1'b0};
    vecs[15] = '{8'd10,  8'h00, 1'b1};
    vecs[16] = '{8'd63,  8'h00, 1'b1};
    vecs[17] = '{8'd255, 8'h00, 1'b1};
    vecs[18] = '{8'd11,  8'h02, 1'b0};

    // Reset state
    rst = 1'b1;
    state_code = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", led, 8'h00);
    chk("reset_busy", {7'h0, busy}, 8'h00);
    chk("reset_err", {7'h0, code_err}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Table of codes, each held until the output is steady
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].code);
      sb.push_back(vecs[i]);
      settle(r, f);
      e = sb.pop_front();
      chk($sformatf("vec%0d_led(code %0d)", i, e.code), led, e.led);
      chk($sformatf("vec%0d_err(code %0d)", i, e.code), {7'h0, code_err}, {7'h0, e.err});
      chk($sformatf("vec%0d_busy(code %0d)", i, e.code), {7'h0, busy}, 8'h00);
    end

    // Latency: code stable from edge k reacts at edge k+3
    drive(8'd23);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef LED_FADE_EN
    chk("lat_busy_k2", {7'h0, busy}, 8'h00);
`else
    chk("lat_led_k2", led, 8'h02);
`endif
    @(posedge clk); #1;
`ifdef LED_FADE_EN
    chk("lat_busy_k3", {7'h0, busy}, 8'h01);
`else
    chk("lat_led_k3", led, 8'h18);
`endif
    settle(r, f);
    chk("lat_final_led", led, 8'h18);

    drive(8'd11);
    settle(r, f);
    chk("back_to_11", led, 8'h02);

`ifdef LED_FADE_EN
    // Fade ramp 0x02 -> 0x18: bit 1 and bits 3/4 share each PWM period
    begin
      int nb, bad, win, prev, mono_bad, w;
      drive(8'd23);
      w = 0;
      while (!busy && w < 16) begin
        @(posedge clk); #1;
        w++;
      end
      chk("ramp_start", {7'h0, busy}, 8'h01);
      nb = 0; bad = 0; win = 0; prev = 0; mono_bad = 0;
      while (busy && nb < 5000) begin
        if (led[1] == led[3] || led[3] != led[4] || (led & 8'hE5) != 8'h00) bad++;
        win += int'(led[3]);
        nb++;
        if (nb % 256 == 0) begin
          if (win < prev) mono_bad++;
          prev = win;
          win = 0;
        end
        @(posedge clk); #1;
      end
      chk_int("ramp_bad_mix", bad, 0);
      chk_int("ramp_duty_falls", mono_bad, 0);
      chk_int("ramp_length_in_range", int'(nb >= 3841 && nb <= 4096), 1);
      chk_int("ramp_end_duty_high", int'(prev >= 200), 1);
      settle(r, f);
      chk("ramp_final_led", led, 8'h18);
      drive(8'd11);
      settle(r, f);
      chk("ramp_back_to_11", led, 8'h02);
    end
`endif

    // One-cycle glitch of 99 must never be accepted
    drive(8'd99);
    drive(8'd11);
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_err", {7'h0, code_err}, 8'h00);
    chk("glitch_led", led, 8'h02);

    // Last code wins: 23 fading, then 37 for two cycles, then 45
    drive(8'd23);
    repeat (10) @(posedge clk);
    #1;
`ifdef LED_FADE_EN
    chk("lw_busy_mid", {7'h0, busy}, 8'h01);
`endif
    drive(8'd37);
    @(negedge clk);
    drive(8'd45);
    settle(r, f);
    chk("lw_final_led", led, 8'hE0);
    chk("lw_err", {7'h0, code_err}, 8'h00);
`ifdef LED_FADE_EN
    chk_int("lw_second_fades", r, 1);
    chk_int("lw_never_all_on", f, 0);
`endif

    // Reset in the middle of a fade toward an invalid code
    drive(8'd70);
    repeat (6) @(posedge clk);
    #1;
    chk("rstmid_err_before", {7'h0, code_err}, 8'h01);
`ifdef LED_FADE_EN
    chk("rstmid_busy_before", {7'h0, busy}, 8'h01);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_led", led, 8'h00);
    chk("rstmid_busy", {7'h0, busy}, 8'h00);
    chk("rstmid_err", {7'h0, code_err}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    state_code = 8'd11;
    settle(r, f);
    chk("after_rst_led", led, 8'h02);
    chk("after_rst_err", {7'h0, code_err}, 8'h00);
`ifdef LED_FADE_EN
    chk_int("after_rst_fade", r, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
